// File: rtl/adc_scan_sequencer_pkg.sv
// Shared types and defaults for the ADC scan sequencer.
package adc_seq_pkg;

    localparam int DATA_W          = 5;
    localparam int SETTLE_CYC_DEF  = 3;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_CONVERT,
        S_CAPTURE,
        S_NEXT
    } state_t;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Control, ADC handshake and result signals of the scan sequencer.
interface adc_scan_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    import adc_seq_pkg::*;

    logic              enable;
    logic              trigger;
    logic              continuous;
    logic [NUM_CH-1:0] ch_mask;
    logic [CH_W-1:0]   muxSel;
    logic              nStartCnv;
    logic              nEndCnv;
    logic [DATA_W-1:0] adcData;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic              scan_done;
    logic              busy;
    logic              timeout_err;

    // sequencer side
    modport master (
        input  enable, trigger, continuous, ch_mask, nEndCnv, adcData,
        output muxSel, nStartCnv, res_valid, res_ch, res_data, scan_done, busy, timeout_err
    );

    // environment side (ADC, mux, host)
    modport slave (
        output enable, trigger, continuous, ch_mask, nEndCnv, adcData,
        input  muxSel, nStartCnv, res_valid, res_ch, res_data, scan_done, busy, timeout_err
    );

endinterface

// File: rtl/adc_scan_sequencer_next_ch.sv
// Priority finder: lowest enabled channel above cur, or lowest overall when first=1.
module adc_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    // scan upward, keep the first hit
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i] && (first || (CH_W'(i) > cur))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan controller: mux stepping, settle, ADC handshake, result beats, watchdog.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic        clock,
    input logic        reset,
    adc_scan_if.master bus
);

    localparam int              WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYC - 1);

    state_t            state, state_d;
    logic [NUM_CH-1:0] scan_mask, scan_mask_d;
    logic [7:0]        settle_cnt, settle_cnt_d;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_d;
    logic              auto_ok, auto_ok_d;   // last scan ended with scan_done
    logic [CH_W-1:0]   mux_d, res_ch_d;
    logic [DATA_W-1:0] res_data_d;
    logic              nstart_d, res_valid_d, scan_done_d, tmo_d;

    logic [CH_W-1:0]   first_ch, next_ch;
    logic              first_found, next_found;

    // lowest channel of the live mask, used to start (or restart) a scan
    adc_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_first (
        .mask (bus.ch_mask),
        .cur  ('0),
        .first(1'b1),
        .nxt  (first_ch),
        .found(first_found)
    );

    // next channel of the latched mask above the current one
    adc_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next (
        .mask (scan_mask),
        .cur  (bus.muxSel),
        .first(1'b0),
        .nxt  (next_ch),
        .found(next_found)
    );

    // next-state and next-output decode
    always_comb begin
        state_d      = state;
        scan_mask_d  = scan_mask;
        settle_cnt_d = settle_cnt;
        wd_cnt_d     = wd_cnt;
        auto_ok_d    = auto_ok;
        mux_d        = bus.muxSel;
        nstart_d     = bus.nStartCnv;
        res_valid_d  = 1'b0;
        res_ch_d     = bus.res_ch;
        res_data_d   = bus.res_data;
        scan_done_d  = 1'b0;
        tmo_d        = bus.timeout_err;
        case (state)
            S_IDLE: begin
                if (bus.enable && first_found && (bus.trigger || (bus.continuous && auto_ok))) begin
                    scan_mask_d  = bus.ch_mask;
                    tmo_d        = 1'b0;
                    mux_d        = first_ch;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    nstart_d = 1'b0;
                    wd_cnt_d = '0;
                    state_d  = S_START;
                end else begin
                    settle_cnt_d = settle_cnt - 8'd1;
                end
            end
            S_START: begin
                if (bus.nEndCnv) begin
                    nstart_d = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = S_CONVERT;
                end else if (wd_cnt == WD_LAST) begin
                    nstart_d  = 1'b1;
                    tmo_d     = 1'b1;
                    auto_ok_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + 1'b1;
                end
            end
            S_CONVERT: begin
                // START already saw the rise, so a low here means the result is ready
                if (!bus.nEndCnv) begin
                    state_d = S_CAPTURE;
                end else if (wd_cnt == WD_LAST) begin
                    tmo_d     = 1'b1;
                    auto_ok_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                res_valid_d = 1'b1;
                res_ch_d    = bus.muxSel;
                res_data_d  = bus.adcData;
                state_d     = S_NEXT;
            end
            S_NEXT: begin
                if (!bus.enable) begin
                    // aborted scan: no scan_done and no auto-restart
                    auto_ok_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (next_found) begin
                    mux_d        = next_ch;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = S_SETTLE;
                end else begin
                    scan_done_d = 1'b1;
                    auto_ok_d   = 1'b1;
                    if (bus.continuous && first_found) begin
                        scan_mask_d  = bus.ch_mask;
                        mux_d        = first_ch;
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            scan_mask       <= '0;
            settle_cnt      <= '0;
            wd_cnt          <= '0;
            auto_ok         <= 1'b0;
            bus.muxSel      <= '0;
            bus.nStartCnv   <= 1'b1;
            bus.res_valid   <= 1'b0;
            bus.res_ch      <= '0;
            bus.res_data    <= '0;
            bus.scan_done   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= state_d;
            scan_mask       <= scan_mask_d;
            settle_cnt      <= settle_cnt_d;
            wd_cnt          <= wd_cnt_d;
            auto_ok         <= auto_ok_d;
            bus.muxSel      <= mux_d;
            bus.nStartCnv   <= nstart_d;
            bus.res_valid   <= res_valid_d;
            bus.res_ch      <= res_ch_d;
            bus.res_data    <= res_data_d;
            bus.scan_done   <= scan_done_d;
            bus.busy        <= (state_d != S_IDLE);
            bus.timeout_err <= tmo_d;
        end
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Multi-channel scan controller for the 5-bit SAR ADC.
- Steps an external analog mux through the enabled channels and, for each one, waits a settling time, then runs the nStartCnv/nEndCnv handshake with the converter.
- Captures each conversion result and presents it as a tagged result beat; supports single-scan and continuous modes, with a watchdog that aborts a hung conversion.

Parameters:
- NUM_CH, 4, number of analog channels; legal range 2..16.
- CH_W, 2, channel index width; equals clog2(NUM_CH).
- DATA_W, 5, conversion result width; matches the ADC dataOut width.
- SETTLE_CYC, 3, clocks to wait after muxSel changes before starting a conversion; legal range 1..255.
- TIMEOUT_CYC, 64, maximum clocks allowed in START or in CONVERT before an abort.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  sequencer enable
- trigger  in  1  single-cycle pulse; starts one scan
- continuous  in  1  1 = restart automatically after each scan
- ch_mask  in  NUM_CH  per-channel enable; sampled at scan start
- muxSel  out  CH_W  analog mux select
- nStartCnv  out  1  active-low start request to the ADC
- nEndCnv  in  1  ADC busy flag; 1 = converting
- adcData  in  DATA_W  ADC dataOut
- res_valid  out  1  one-cycle pulse: result beat
- res_ch  out  CH_W  channel of the result
- res_data  out  DATA_W  captured result
- scan_done  out  1  one-cycle pulse after the last channel of a scan
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, reset low), values of every output: muxSel=0, nStartCnv=1, res_valid=0, res_ch=0, res_data=0, scan_done=0, busy=0, timeout_err=0. State goes to IDLE; counters and the latched mask clear to 0. All outputs are registered.
- States: IDLE, SETTLE, START, CONVERT, CAPTURE, NEXT.
- IDLE:
  - Leaves only when enable=1, ch_mask!=0, and either trigger=1 or (continuous=1 and the last scan completed normally).
  - On leaving: latch ch_mask to scan_mask; timeout_err clears; muxSel = lowest set bit of scan_mask; load the settle counter; go to SETTLE.
  - A trigger with mask=0 or enable=0 is dropped, with no response.
- SETTLE: counts SETTLE_CYC clocks, then goes to START with nStartCnv driven 0.
- START:
  - nStartCnv holds 0 until nEndCnv=1 is sampled.
  - Then nStartCnv returns to 1 and the state goes to CONVERT.
- CONVERT: waits for nEndCnv=0, then goes to CAPTURE.
- CAPTURE:
  - res_data<=adcData, res_ch<=muxSel, res_valid=1 for exactly one cycle.
  - Then go to NEXT.
- NEXT:
  - Search scan_mask for the next set bit strictly above muxSel.
  - If one is found: muxSel updates to that bit; go to SETTLE.
  - If none is found: scan_done=1 for one cycle.
    - If continuous=1 and enable=1: muxSel = lowest set bit of a freshly latched ch_mask; go to SETTLE (if that mask=0, go to IDLE instead).
    - Otherwise go to IDLE.
- Latency, one channel, SETTLE_CYC=3, ADC conversion time Tc: trigger to res_valid = 1 + 3 + handshake + Tc + 1 clocks.
- Watchdog:
  - A counter resets on entry to START and on entry to CONVERT.
  - If it reaches TIMEOUT_CYC in either state: timeout_err<=1, nStartCnv<=1, no res_valid, no scan_done; go to IDLE.
  - Auto-restart is suppressed until the next trigger.
- enable drops mid-scan: the conversion in progress completes through CAPTURE, then the sequencer goes to IDLE with no scan_done.
- trigger while busy: ignored.
- ch_mask changes mid-scan: no effect until the next scan start.
- Single-channel mask: SETTLE is re-entered on every continuous pass, with muxSel unchanged.
- nEndCnv already 0 on entry to CONVERT: handled normally. This is legal because the ADC always raises nEndCnv before clearing it, and START guarantees the rise was seen.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum typedef (3-bit);
  - DATA_W;
  - the default SETTLE_CYC and TIMEOUT_CYC constants.
- Sub-module adc_next_ch: purely combinational priority finder.
  - Inputs: mask[NUM_CH], cur[CH_W], first (1 = search from bit 0).
  - Outputs: nxt[CH_W], found.
  - Used both at scan start and in NEXT.

Test Plan:
- Single scan: ch_mask=4'b1011, trigger pulse, behavioural ADC returning value 5'd10+channel → res beats (ch0,10), (ch1,11), (ch3,13) in that order; scan_done once; then busy=0.
- Settling: SETTLE_CYC=3 → exactly 3 clocks between each muxSel change and nStartCnv falling; nStartCnv rises the cycle after nEndCnv=1 is sampled.
- Continuous mode: continuous=1, ch_mask=4'b0100 → repeated (ch2) beats, each scan followed by scan_done. Deassert enable during CONVERT → that beat still arrives, then IDLE with no further scan_done.
- Watchdog: ADC model never raises nEndCnv, TIMEOUT_CYC=64 → after 64 clocks in START: timeout_err=1, nStartCnv=1, IDLE, no res_valid. A following trigger clears timeout_err.
- Illegal and empty cases: trigger with ch_mask=0 → busy stays 0. Trigger while busy → beat count unchanged. ch_mask changed mid-scan → current scan uses the old mask.
- Async reset: assert reset low during CONVERT → all outputs take their reset values immediately. After release and a trigger, the scan restarts from the lowest enabled channel.
